// File: rtl/lut_layer_rt.sv
// Runtime-reloadable layer of LUT neurons: per-neuron truth tables in distributed RAM,
// a two-stage valid/ready inference pipeline and a drain-then-load configuration controller.
module lut_layer_rt #(
    parameter int NEURONS  = 4,
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    localparam int NB      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NEURONS*IN_BITS-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS*OUT_BITS-1:0]  out_data,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [NB-1:0]                cfg_neuron,
    input  logic [IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    input  logic                         cfg_last,
    output logic                         tbl_loaded
);

    localparam int DEPTH = 1 << IN_BITS;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t                        state, state_nxt;
    logic                          s0_valid;
    logic [NEURONS*IN_BITS-1:0]    s0_addr;
    logic [NEURONS*OUT_BITS-1:0]   lookup;
    logic                          s1_adv;
    logic                          in_fire;
    logic                          cfg_fire;
    logic                          cfg_hit;

    logic [OUT_BITS-1:0] tbl [NEURONS][DEPTH];

    assign s1_adv   = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign cfg_fire = cfg_valid && cfg_ready;
    // Beats aimed past the last neuron are still handshaken, just never written.
    assign cfg_hit  = {1'b0, cfg_neuron} < (NB+1)'(NEURONS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_valid) state_nxt = DRAIN;
            DRAIN:   if (!s0_valid && !out_valid) state_nxt = LOAD;
            LOAD:    if (cfg_valid && cfg_last) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        case (state)
            RUN:     in_ready  = tbl_loaded && (!s0_valid || s1_adv);
            LOAD:    cfg_ready = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the table RAM is deliberately not reset so it maps onto distributed RAM;
    // its contents are undefined until a load writes them.
    always_ff @(posedge clk) begin
        if (cfg_fire && cfg_hit) tbl[cfg_neuron][cfg_addr] <= cfg_data;
    end

    always_comb begin
        lookup = '0;
        for (int n = 0; n < NEURONS; n++)
            lookup[n*OUT_BITS +: OUT_BITS] = tbl[n][s0_addr[n*IN_BITS +: IN_BITS]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid   <= 1'b0;
            s0_addr    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            tbl_loaded <= 1'b0;
        end else begin
            if (in_fire) begin
                s0_valid <= 1'b1;
                s0_addr  <= in_data;
            end else if (s1_adv) begin
                s0_valid <= 1'b0;
            end

            if (s1_adv) begin
                out_valid <= s0_valid;
                if (s0_valid) out_data <= lookup;
            end

            if (cfg_fire && cfg_last) tbl_loaded <= 1'b1;
        end
    end

endmodule
